irq_controller: RTL and testbench

- Platform interrupt controller that schedules access to riscv_core's single interrupt input (irq_req_i / irq_ret_o) among N_IRQ peripheral interrupt lines.
- Detects rising edges and latches them as pending, then applies per-line and global masks.
- Picks one winner by fixed priority, with the lowest index winning.
- Drives the core's request, supplies an mcause-format cause word, and acknowledges the source when the core executes mret.
- Does not support nesting: one interrupt is in flight at a time.

---
 rtl/irq_controller.sv | 226 ++++++++++++++++++++++
 tb/tb_irq_controller.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
//
// Platform interrupt controller in front of riscv_core's single interrupt
// input. Rising edges on irq_i are latched as pending, qualified by the
// per-line mask (mie_i) and the global enable (gie_i), and the lowest-index
// eligible line is presented to the core as one request at a time (no
// nesting). The controller supplies an mcause-format cause word and
// acknowledges the serviced source for one cycle once the core executes mret.
//
// Build option:
//   IRQ_CTRL_SYNC_EN  when defined, every irq_i bit passes through a 2-flop
//                     synchronizer before the edge detector (input-to-request
//                     latency 4 cycles). When undefined, irq_i must already be
//                     synchronous to clk_i (latency 2 cycles).
//
// Parameters:
//   N_IRQ          number of interrupt lines, 1..16
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous, active-low reset
//   irq_i          peripheral interrupt lines, rising edge raises a request
//   mie_i          per-line enable mask
//   gie_i          global interrupt enable (mstatus.MIE)
//   irq_taken_i    1-cycle pulse: core entered the trap handler
//   irq_ret_i      1-cycle pulse: core executed mret
//   irq_req_o      interrupt request to the core
//   irq_cause_o    mcause value of the request in flight (0x8000_0010 + idx)
//   irq_ack_o      one-hot, 1-cycle acknowledge to the serviced source
//   irq_pending_o  pending register, for mip readback
//   busy_o         an interrupt is in REQ or SERVICE
// -----------------------------------------------------------------------------
module irq_controller #(
    parameter int N_IRQ = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic [N_IRQ-1:0] mie_i,
    input  logic             gie_i,
    input  logic             irq_taken_i,
    input  logic             irq_ret_i,
    output logic             irq_req_o,
    output logic [31:0]      irq_cause_o,
    output logic [N_IRQ-1:0] irq_ack_o,
    output logic [N_IRQ-1:0] irq_pending_o,
    output logic             busy_o
);

    localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [N_IRQ-1:0]   irq_in;
    logic [N_IRQ-1:0]   irq_q_reg;
    logic [N_IRQ-1:0]   rise;
    logic [N_IRQ-1:0]   pending_reg;
    logic [N_IRQ-1:0]   pending_next;
    logic [N_IRQ-1:0]   elig;
    logic               elig_any;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   idx_reg;
    logic [N_IRQ-1:0]   ack_onehot;
    logic [N_IRQ-1:0]   ack_reg;
    logic [31:0]        cause_reg;
    logic               start_req;
    logic               finish_svc;

    // -------------------------------------------------------------------------
    // Input conditioning
    // -------------------------------------------------------------------------
`ifdef IRQ_CTRL_SYNC_EN
    logic [N_IRQ-1:0]   sync1_reg;
    logic [N_IRQ-1:0]   sync2_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= irq_i;
            sync2_reg <= sync1_reg;
        end
    end

    assign irq_in = sync2_reg;
`else
    assign irq_in = irq_i;
`endif

    // -------------------------------------------------------------------------
    // Edge detect and pending register
    // -------------------------------------------------------------------------
    // The clear for the serviced line is driven by the registered ack, so it
    // lands at the end of the ack cycle. A fresh edge arriving in that same
    // cycle re-sets the bit (set has priority), which re-arms the line.
    genvar gi;
    generate
        for (gi = 0; gi < N_IRQ; gi++) begin : g_line
            assign rise[gi]         = irq_in[gi] & ~irq_q_reg[gi];
            assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~ack_reg[gi]);
            assign ack_onehot[gi]   = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q_reg   <= '0;
            pending_reg <= '0;
        end else begin
            irq_q_reg   <= irq_in;
            pending_reg <= pending_next;
        end
    end

    // -------------------------------------------------------------------------
    // Eligibility and fixed-priority pick (lowest index wins)
    // -------------------------------------------------------------------------
    assign elig     = gie_i ? (pending_reg & mie_i) : '0;
    assign elig_any = |elig;

    always_comb begin
        winner = '0;
        // Scan from the top so the lowest set index is the last one written.
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                winner = IDX_W'(i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // IDLE holds off during the ack cycle: the serviced line's pending bit is
    // still set then, and the next pick must see the cleared register.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (elig_any && (ack_reg == '0)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                // Taken wins over a simultaneous ret; masks are not re-checked.
                if (irq_taken_i) begin
                    state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (irq_ret_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (decoded from the state register only)
    // -------------------------------------------------------------------------
    always_comb begin
        irq_req_o = 1'b0;
        busy_o    = 1'b0;
        case (state_reg)
            REQ: begin
                irq_req_o = 1'b1;
                busy_o    = 1'b1;
            end
            SERVICE: begin
                busy_o    = 1'b1;
            end
            default: begin
                irq_req_o = 1'b0;
                busy_o    = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // In-flight index, cause word and acknowledge
    // -------------------------------------------------------------------------
    assign start_req  = (state_reg == IDLE) && (state_next == REQ);
    assign finish_svc = (state_reg == SERVICE) && irq_ret_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_reg   <= '0;
            cause_reg <= '0;
            ack_reg   <= '0;
        end else begin
            if (start_req) begin
                idx_reg   <= winner;
                cause_reg <= {1'b1, 26'b0, 5'd16 + 5'(winner)};
            end
            ack_reg <= finish_svc ? ack_onehot : '0;
        end
    end

    assign irq_cause_o   = cause_reg;
    assign irq_ack_o     = ack_reg;
    assign irq_pending_o = pending_reg;

endmodule

// File: tb/tb_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_irq_controller
//
// Directed bench for irq_controller (N_IRQ=16). Expected cause words are
// queued when an interrupt line is driven and popped when the request shows
// up; expected acks are queued when mret is pulsed and popped when the ack
// appears. Inputs change and outputs are sampled 1 ns after the rising edge.
// Builds with or without IRQ_CTRL_SYNC_EN; only the input latency differs.
// -----------------------------------------------------------------------------
module tb_irq_controller;

    localparam int N = 16;
`ifdef IRQ_CTRL_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  irq;
    logic [N-1:0]  mie;
    logic          gie;
    logic          taken;
    logic          ret;
    logic          req;
    logic [31:0]   cause;
    logic [N-1:0]  ack;
    logic [N-1:0]  pending;
    logic          busy;

    int            n_cmp = 0;
    int            n_bad = 0;

    logic [31:0]   cause_q[$];
    logic [N-1:0]  ack_q[$];

    irq_controller #(.N_IRQ(N)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .irq_i         (irq),
        .mie_i         (mie),
        .gie_i         (gie),
        .irq_taken_i   (taken),
        .irq_ret_i     (ret),
        .irq_req_o     (req),
        .irq_cause_o   (cause),
        .irq_ack_o     (ack),
        .irq_pending_o (pending),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Pop the next expected cause and compare it with the cause on the bus.
    task automatic pop_cause(input string tag);
        logic [31:0] e;
        if (cause_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s: observed request with cause 0x%08h expected none queued", tag, cause);
        end else begin
            e = cause_q.pop_front();
            chk(tag, cause, e);
            $display("req   %-12s cause=0x%08h", tag, cause);
        end
    endtask

    task automatic pop_ack(input string tag);
        logic [N-1:0] e;
        if (ack_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s: observed ack 0x%04h expected none queued", tag, ack);
        end else begin
            e = ack_q.pop_front();
            chk(tag, 32'(ack), 32'(e));
            $display("ack   %-12s ack=0x%04h", tag, ack);
        end
    endtask

    // Bounded wait for irq_req_o; an expired budget shows up as a failed check.
    task automatic wait_req(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (!req && n < max_cycles) begin
            tick();
            n++;
        end
        chk(tag, 32'(req), 32'd1);
    endtask

    // taken -> SERVICE, ret -> ack for one cycle. Ends in the cycle after the ack.
    task automatic service(input string tag, input logic [N-1:0] exp_ack);
        taken = 1'b1;
        tick();
        taken = 1'b0;
        chk({tag, "_req_drop"}, 32'(req), 32'd0);
        chk({tag, "_busy_svc"}, 32'(busy), 32'd1);
        ret = 1'b1;
        ack_q.push_back(exp_ack);
        tick();
        ret = 1'b0;
        pop_ack({tag, "_ack"});
        tick();
        chk({tag, "_ack_1cyc"}, 32'(ack), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        irq   = '0;
        mie   = '0;
        gie   = 1'b0;
        taken = 1'b0;
        ret   = 1'b0;
        tick();
        tick();

        // ---- reset state ----
        chk("rst_req",     32'(req),     32'd0);
        chk("rst_cause",   cause,        32'd0);
        chk("rst_ack",     32'(ack),     32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        rst_n = 1'b1;
        gie   = 1'b1;
        mie   = 16'hFFFF;
        tick();

        // ---- basic service on line 3 ----
        irq[3] = 1'b1;
        cause_q.push_back(32'h8000_0013);
        repeat (LAT - 1) tick();
        chk("basic_early", 32'(req), 32'd0);
        tick();
        chk("basic_req", 32'(req), 32'd1);
        pop_cause("basic_cause");
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_pend", 32'(pending), 32'h0008);
        irq[3] = 1'b0;
        service("basic", 16'h0008);
        chk("basic_pclr", 32'(pending), 32'd0);
        chk("basic_idle", 32'(busy), 32'd0);
        chk("basic_hold", cause, 32'h8000_0013);

        // ---- priority: lines 5 and 2 together ----
        irq[5] = 1'b1;
        irq[2] = 1'b1;
        cause_q.push_back(32'h8000_0012);
        cause_q.push_back(32'h8000_0015);
        repeat (LAT) tick();
        chk("prio_req1", 32'(req), 32'd1);
        pop_cause("prio_c1");
        irq = '0;
        service("prio1", 16'h0004);
        chk("prio_gap", 32'(req), 32'd0);
        tick();
        chk("prio_req2", 32'(req), 32'd1);
        pop_cause("prio_c2");
        service("prio2", 16'h0020);

        // ---- per-line mask ----
        mie = '0;
        irq[7] = 1'b1;
        repeat (LAT + 2) tick();
        chk("mask_pend", 32'(pending), 32'h0080);
        chk("mask_noreq", 32'(req), 32'd0);
        mie[7] = 1'b1;
        cause_q.push_back(32'h8000_0017);
        wait_req("mask_req", 2);
        pop_cause("mask_cause");
        irq[7] = 1'b0;
        service("mask", 16'h0080);

        // ---- global enable ----
        mie = 16'hFFFF;
        gie = 1'b0;
        irq[9] = 1'b1;
        repeat (LAT + 2) tick();
        chk("gie_pend", 32'(pending), 32'h0200);
        chk("gie_noreq", 32'(req), 32'd0);
        gie = 1'b1;
        cause_q.push_back(32'h8000_0019);
        wait_req("gie_req", 2);
        pop_cause("gie_cause");
        irq[9] = 1'b0;
        service("gie", 16'h0200);

        // ---- no withdrawal once in REQ ----
        irq[3] = 1'b1;
        cause_q.push_back(32'h8000_0013);
        repeat (LAT) tick();
        chk("hold_req", 32'(req), 32'd1);
        pop_cause("hold_cause");
        mie = '0;
        gie = 1'b0;
        repeat (3) tick();
        chk("hold_stay", 32'(req), 32'd1);
        mie = 16'hFFFF;
        gie = 1'b1;

        // ---- re-arm: new edge on line 3 in its own ack cycle ----
        taken = 1'b1;
        tick();
        taken = 1'b0;
        irq[3] = 1'b0;
        tick();
        ret = 1'b1;
        ack_q.push_back(16'h0008);
        tick();
        ret = 1'b0;
        pop_ack("rearm_ack");
        irq[3] = 1'b1;
`ifdef IRQ_CTRL_SYNC_EN
        // The synchronizer delays the new edge past the ack; only the
        // follow-up request is checked in this build.
        cause_q.push_back(32'h8000_0013);
        wait_req("rearm_req", 8);
        pop_cause("rearm_cause");
`else
        cause_q.push_back(32'h8000_0013);
        tick();
        chk("rearm_pend", 32'(pending), 32'h0008);
        chk("rearm_gap", 32'(req), 32'd0);
        tick();
        chk("rearm_req", 32'(req), 32'd1);
        pop_cause("rearm_cause");
`endif

        // ---- async reset mid-SERVICE ----
        taken = 1'b1;
        tick();
        taken = 1'b0;
        chk("arst_svc", 32'(busy), 32'd1);
        irq = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req",   32'(req),     32'd0);
        chk("arst_busy",  32'(busy),    32'd0);
        chk("arst_cause", cause,        32'd0);
        chk("arst_pend",  32'(pending), 32'd0);
        chk("arst_ack",   32'(ack),     32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        ret = 1'b1;
        tick();
        ret = 1'b0;
        chk("arst_noack", 32'(ack), 32'd0);
        tick();
        chk("arst_noack2", 32'(ack), 32'd0);
        chk("arst_idle",   32'(busy), 32'd0);

        // ---- spurious taken/ret in IDLE, then line 0 latency ----
        taken = 1'b1;
        ret   = 1'b1;
        tick();
        taken = 1'b0;
        ret   = 1'b0;
        chk("spur_req", 32'(req), 32'd0);
        tick();
        chk("spur_ack", 32'(ack), 32'd0);
        chk("spur_busy", 32'(busy), 32'd0);

        irq[0] = 1'b1;
        cause_q.push_back(32'h8000_0010);
        repeat (LAT - 1) tick();
        chk("lat0_early", 32'(req), 32'd0);
        tick();
        chk("lat0_req", 32'(req), 32'd1);
        pop_cause("lat0_cause");
        // taken and ret together in REQ: taken honoured, ret ignored
        taken = 1'b1;
        ret   = 1'b1;
        tick();
        taken = 1'b0;
        ret   = 1'b0;
        chk("both_svc", 32'(busy), 32'd1);
        chk("both_req", 32'(req), 32'd0);
        tick();
        chk("both_noack", 32'(ack), 32'd0);
        irq = '0;
        ret = 1'b1;
        ack_q.push_back(16'h0001);
        tick();
        ret = 1'b0;
        pop_ack("lat0_ack");
        tick();
        chk("end_pend", 32'(pending), 32'd0);

        chk("sb_empty", 32'(cause_q.size() + ack_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed time limit reached expected bench completion");
        $fatal(1, "watchdog");
    end

endmodule
